// File: rtl/mti_cpi_sequencer.sv
// CPI sequencer for the 2-pulse MTI canceller.
// Counts range bins and pulses, gates the canceller, flags timing faults.
module mti_cpi_sequencer #(
    parameter int RANGE_W = 12,
    parameter int PULSE_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [RANGE_W-1:0] cfg_num_bins,
    input  logic [PULSE_W-1:0] cfg_num_pulses,
    input  logic               start,
    input  logic               abort,
    input  logic               pulse_sync,
    input  logic               sample_valid,
    output logic               sample_accept,
    output logic               filt_enable,
    output logic               first_pulse,
    output logic [RANGE_W-1:0] range_idx,
    output logic [PULSE_W-1:0] pulse_idx,
    output logic               busy,
    output logic               cpi_done,
    output logic               err_overrun,
    output logic               err_short_pulse
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        COLLECT   = 2'd2,
        DONE      = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [RANGE_W-1:0] bins_q, bins_d;
    logic [PULSE_W-1:0] pulses_q, pulses_d;
    logic [RANGE_W-1:0] range_q, range_d;
    logic [PULSE_W-1:0] pulse_q, pulse_d;
    logic               ovr_q, ovr_d;
    logic               short_q, short_d;

    logic start_ok;
    logic last_bin;
    logic last_pulse;

    assign start_ok   = start && (cfg_num_bins != '0) && (cfg_num_pulses != '0);
    assign last_bin   = (range_q == bins_q - RANGE_W'(1));
    assign last_pulse = (pulse_q == pulses_q - PULSE_W'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; abort overrides everything
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) state_d = WAIT_SYNC;
            end
            WAIT_SYNC: begin
                if (pulse_sync) state_d = COLLECT;
            end
            COLLECT: begin
                if (sample_valid && last_bin) begin
                    if (last_pulse)      state_d = DONE;
                    else if (pulse_sync) state_d = COLLECT;
                    else                 state_d = WAIT_SYNC;
                end else if (pulse_sync && last_pulse) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // Outputs decoded from state and counters
    always_comb begin
        busy          = (state_q != IDLE);
        filt_enable   = (state_q == COLLECT);
        sample_accept = sample_valid && (state_q == COLLECT);
        cpi_done      = (state_q == DONE) && !abort;
        range_idx     = range_q;
        pulse_idx     = pulse_q;
        first_pulse   = (pulse_q == '0) && (state_q != IDLE);
        err_overrun     = ovr_q;
        err_short_pulse = short_q;
    end

    // Counter, config latch and error flag next-state
    always_comb begin
        bins_d   = bins_q;
        pulses_d = pulses_q;
        range_d  = range_q;
        pulse_d  = pulse_q;
        ovr_d    = ovr_q;
        short_d  = short_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    bins_d   = cfg_num_bins;
                    pulses_d = cfg_num_pulses;
                    range_d  = '0;
                    pulse_d  = '0;
                    ovr_d    = 1'b0;
                    short_d  = 1'b0;
                end
            end
            WAIT_SYNC: begin
                if (sample_valid) ovr_d = 1'b1;
                if (pulse_sync)   range_d = '0;
            end
            COLLECT: begin
                if (sample_valid && last_bin) begin
                    // Completing sample; a coincident sync just opens the next pulse
                    if (!last_pulse) begin
                        range_d = '0;
                        pulse_d = pulse_q + PULSE_W'(1);
                    end
                end else if (pulse_sync) begin
                    // Early sync truncates the pulse in progress
                    short_d = 1'b1;
                    if (!last_pulse) begin
                        range_d = '0;
                        pulse_d = pulse_q + PULSE_W'(1);
                    end
                end else if (sample_valid) begin
                    range_d = range_q + RANGE_W'(1);
                end
            end
            DONE: begin
            end
            default: begin
            end
        endcase
        if (abort) begin
            range_d = '0;
            pulse_d = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bins_q   <= '0;
            pulses_q <= '0;
            range_q  <= '0;
            pulse_q  <= '0;
            ovr_q    <= 1'b0;
            short_q  <= 1'b0;
        end else begin
            bins_q   <= bins_d;
            pulses_q <= pulses_d;
            range_q  <= range_d;
            pulse_q  <= pulse_d;
            ovr_q    <= ovr_d;
            short_q  <= short_d;
        end
    end

endmodule

// File: doc/mti_cpi_sequencer.md
Name: mti_cpi_sequencer

Overview:
Controls the 2-pulse MTI canceller over one coherent processing interval (CPI). Counts range bins per pulse and pulses per CPI. Gates the canceller enable, flags the first pulse of the CPI (no valid difference exists for it), and tags each accepted sample with range/pulse indices. Flags timing faults from the PRF trigger and ADC sample stream. Sits between the radar timing generator / ADC sample path and the MTI filter.

Parameters:
RANGE_W, 12, width of range-bin count and index
PULSE_W, 8, width of pulse count and index

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cfg_num_bins  in  RANGE_W  range bins per pulse; latched on accepted start
cfg_num_pulses  in  PULSE_W  pulses per CPI; latched on accepted start
start  in  1  begin CPI (level sampled, 1-cycle pulse expected)
abort  in  1  terminate CPI immediately
pulse_sync  in  1  PRF trigger, 1-cycle pulse marking start of a pulse
sample_valid  in  1  ADC sample present this cycle
sample_accept  out  1  sample forwarded to canceller this cycle
filt_enable  out  1  canceller enable
first_pulse  out  1  current pulse is pulse 0 of CPI
range_idx  out  RANGE_W  range bin of current sample
pulse_idx  out  PULSE_W  pulse number of current sample
busy  out  1  CPI in progress
cpi_done  out  1  1-cycle pulse at CPI completion
err_overrun  out  1  sticky: sample arrived outside a pulse window
err_short_pulse  out  1  sticky: pulse_sync arrived before pulse completed

Behaviour:
- Reset: state IDLE; all outputs 0; latched config 0; counters 0.
- States: IDLE, WAIT_SYNC, COLLECT, DONE. All state and counter updates on posedge clk.
- Outputs:
  - busy = (state != IDLE).
  - filt_enable = (state == COLLECT).
  - sample_accept = sample_valid && state == COLLECT (combinational).
  - first_pulse = (pulse_idx == 0) && busy.
  - range_idx, pulse_idx driven directly from counter registers.
- IDLE:
  - start with both cfg values nonzero: latch config, clear both counters and both error flags, go to WAIT_SYNC.
  - start with either cfg value zero: ignored; stay IDLE; no flag change.
- WAIT_SYNC:
  - pulse_sync: go to COLLECT, range_idx = 0.
  - sample_valid: dropped; set err_overrun.
- COLLECT, accepted sample:
  - Not last bin (range_idx != num_bins-1): range_idx++.
  - Last bin, last pulse (pulse_idx == num_pulses-1): go to DONE.
  - Last bin, other pulse: range_idx = 0, pulse_idx++, go to WAIT_SYNC.
- COLLECT, pulse_sync without completion: set err_short_pulse; truncate current pulse.
  - If it was the last pulse: go to DONE; the sync is ignored.
  - Otherwise: pulse_idx++, range_idx = 0, stay in COLLECT.
- Simultaneous sample_valid and pulse_sync in COLLECT: sample is accepted and counted to the old pulse first.
  - If that sample completes a non-last pulse: the sync starts the next pulse directly (pulse_idx++, range_idx = 0, stay COLLECT); no error.
  - If that sample completes the last pulse: go to DONE; sync ignored.
  - Otherwise: short-pulse handling applies.
- DONE: cpi_done = 1 for exactly that one cycle; go to IDLE. Counters hold until the next start.
- abort: highest priority, any state. Next state IDLE, counters cleared, cpi_done not asserted, error flags retained.
- start while busy: ignored.
- Counter wrap: impossible by construction; indices never exceed latched count - 1. Max config values (all ones) are legal.
- Config inputs changing mid-CPI: no effect until the next accepted start.

Test Plan:
- Nominal: bins=4, pulses=3; start; 3×(pulse_sync, 4 samples) -> sample_accept on 12 samples; range_idx 0..3 each pulse; pulse_idx 0,1,2; first_pulse only during pulse 0; cpi_done single cycle after 12th sample; busy falls next cycle; no error flags set.
- Overrun: bins=4, pulses=2; sample_valid in WAIT_SYNC -> sample_accept=0, err_overrun=1 (sticky), CPI still completes normally.
- Short pulse: bins=8, pulses=2; pulse_sync after 5 samples -> err_short_pulse=1, pulse_idx=1, range_idx=0; after 8 more samples cpi_done=1.
- Coincident: bins=2, pulses=2; last sample of pulse 0 on same cycle as pulse_sync -> no error; next accepted sample tagged pulse_idx=1, range_idx=0.
- Abort and zero config: abort mid-pulse 1 -> IDLE next cycle, no cpi_done, counters 0; start with bins=0 -> busy stays 0.
